// File: rtl/multi_mem_if.sv
// Port bundle for the byte-write / word-read line buffer RAM.
// Master drives both address/enable groups; slave returns the registered word.
interface multi_mem_if #(
  parameter int A_ADDR_WIDTH = 12,
  parameter int A_DATA_WIDTH = 8,
  parameter int B_ADDR_WIDTH = 11,
  parameter int B_DATA_WIDTH = 16
);
  logic [A_DATA_WIDTH-1:0] DataInA;
  logic [A_ADDR_WIDTH-1:0] AddressA;
  logic                    ClockEnA;
  logic                    WrA;
  logic [B_ADDR_WIDTH-1:0] AddressB;
  logic                    ClockEnB;
  logic [B_DATA_WIDTH-1:0] QB;

  modport master (
    output DataInA, AddressA, ClockEnA, WrA, AddressB, ClockEnB,
    input  QB
  );

  modport slave (
    input  DataInA, AddressA, ClockEnA, WrA, AddressB, ClockEnB,
    output QB
  );
endinterface

// File: rtl/multi_mem.sv
// Asymmetric simple-dual-port RAM: byte writes on port A, packed-word reads on port B.
// Read latency 1 cycle, read-first on collision; no backpressure, ClockEnB stalls QB.
module multi_mem #(
  parameter int A_ADDR_WIDTH = 12,
  parameter int A_DATA_WIDTH = 8,
  parameter int B_ADDR_WIDTH = 11,
  parameter int B_DATA_WIDTH = 16
) (
  input  logic          Clock,
  input  logic          Reset,
  multi_mem_if.slave    bus
);

  localparam int RATIO      = B_DATA_WIDTH / A_DATA_WIDTH;
  localparam int RATIO_LOG2 = $clog2(RATIO);
  localparam int DEPTH      = 2 ** A_ADDR_WIDTH;

  // Reject width combinations that cannot pack whole bytes into a word.
  if ((B_DATA_WIDTH % A_DATA_WIDTH) != 0 || RATIO < 1 ||
      (RATIO & (RATIO - 1)) != 0 ||
      B_ADDR_WIDTH != A_ADDR_WIDTH - RATIO_LOG2) begin : g_bad_params
    $error("multi_mem: illegal A/B width combination");
  end

  logic [A_DATA_WIDTH-1:0] mem [DEPTH];
  logic [B_DATA_WIDTH-1:0] q_r;

  function automatic logic [A_ADDR_WIDTH-1:0] byte_addr(
    input logic [B_ADDR_WIDTH-1:0] word_addr,
    input int                      lane
  );
    byte_addr = A_ADDR_WIDTH'((int'(word_addr) << RATIO_LOG2) + lane);
  endfunction

  always_ff @(posedge Clock) begin
    if (bus.ClockEnA && bus.WrA) begin
      mem[bus.AddressA] <= bus.DataInA;
    end
  end

  // Non-blocking write above means this read sees pre-edge contents (read-first).
  always_ff @(posedge Clock) begin
    if (Reset) begin
      q_r <= '0;
    end else if (bus.ClockEnB) begin
      for (int k = 0; k < RATIO; k++) begin
        q_r[k*A_DATA_WIDTH +: A_DATA_WIDTH] <= mem[byte_addr(bus.AddressB, k)];
      end
    end
  end

  assign bus.QB = q_r;

endmodule

// File: tb/tb_multi_mem.sv
// Bench for multi_mem: directed scenarios with literal expectations, then random
// traffic; a byte-array model is compared against QB on every cycle.
module tb_multi_mem;

  logic clk;
  logic rst;
  int   n_chk  = 0;
  int   n_pass = 0;
  bit   chk_en = 1'b0;

  multi_mem_if #(.A_ADDR_WIDTH(12), .A_DATA_WIDTH(8),
                 .B_ADDR_WIDTH(11), .B_DATA_WIDTH(16)) bus ();

  multi_mem #(.A_ADDR_WIDTH(12), .A_DATA_WIDTH(8),
              .B_ADDR_WIDTH(11), .B_DATA_WIDTH(16)) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain byte array, word = {high byte, low byte}, read before write.
  logic [7:0]  mm [4096];
  logic [15:0] model_qb;

  initial begin
    for (int i = 0; i < 4096; i++) mm[i] = 8'h00;
    model_qb = 16'h0000;
  end

  always @(posedge clk) begin
    logic [15:0] nxt;
    nxt = model_qb;
    if (rst)
      nxt = 16'h0000;
    else if (bus.ClockEnB)
      nxt = {mm[int'(bus.AddressB) * 2 + 1], mm[int'(bus.AddressB) * 2]};
    if (bus.ClockEnA && bus.WrA)
      mm[bus.AddressA] = bus.DataInA;
    model_qb = nxt;
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (chk_en) chk("qb_vs_model", bus.QB, model_qb);
  end

  // Apply one cycle of inputs, then return at the following negedge.
  task automatic cyc(input logic r,
                     input logic cea, input logic wra, input logic [11:0] aa, input logic [7:0] da,
                     input logic ceb, input logic [10:0] ab);
    rst          = r;
    bus.ClockEnA = cea;
    bus.WrA      = wra;
    bus.AddressA = aa;
    bus.DataInA  = da;
    bus.ClockEnB = ceb;
    bus.AddressB = ab;
    @(negedge clk);
  endtask

  task automatic wr(input logic [11:0] aa, input logic [7:0] da);
    cyc(1'b0, 1'b1, 1'b1, aa, da, 1'b0, 11'h000);
  endtask

  task automatic rd(input logic [10:0] ab);
    cyc(1'b0, 1'b0, 1'b0, 12'h000, 8'h00, 1'b1, ab);
  endtask

  initial begin
    rst = 1'b0;
    bus.ClockEnA = 1'b0; bus.WrA = 1'b0; bus.AddressA = '0; bus.DataInA = '0;
    bus.ClockEnB = 1'b0; bus.AddressB = '0;
    @(negedge clk);

    // Reset for two cycles with the read port enabled.
    cyc(1'b1, 1'b0, 1'b0, 12'h000, 8'h00, 1'b1, 11'h7FF);
    chk_en = 1'b1;
    chk("reset_1", bus.QB, 16'h0000);
    cyc(1'b1, 1'b0, 1'b0, 12'h000, 8'h00, 1'b1, 11'h7FF);
    chk("reset_2", bus.QB, 16'h0000);

    // Top word packing.
    wr(12'hFFF, 8'h41);
    wr(12'hFFE, 8'h42);
    rd(11'h7FF);
    chk("pack_top", bus.QB, 16'h4142);

    // Hold while ClockEnB is low.
    wr(12'hFFF, 8'h43);
    rd(11'h7FF);
    chk("update_hi", bus.QB, 16'h4342);
    wr(12'hFFF, 8'h44);
    chk("hold_1", bus.QB, 16'h4342);
    cyc(1'b0, 1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 11'h7FF);
    chk("hold_2", bus.QB, 16'h4342);
    rd(11'h7FF);
    chk("resume", bus.QB, 16'h4442);

    // Same-edge read and write of the low byte returns the old byte.
    cyc(1'b0, 1'b1, 1'b1, 12'hFFE, 8'h45, 1'b1, 11'h7FF);
    chk("rdw_old_1", bus.QB, 16'h4442);
    rd(11'h7FF);
    chk("rdw_new_1", bus.QB, 16'h4445);
    cyc(1'b0, 1'b1, 1'b1, 12'hFFE, 8'h46, 1'b1, 11'h7FF);
    chk("rdw_old_2", bus.QB, 16'h4445);
    rd(11'h7FF);
    chk("rdw_new_2", bus.QB, 16'h4446);

    // Mid-range word with repeated writes while reading every cycle.
    cyc(1'b0, 1'b1, 1'b1, 12'h7FF, 8'h5A, 1'b1, 11'h3FF);
    chk("half_1", bus.QB, 16'h0000);
    cyc(1'b0, 1'b1, 1'b1, 12'h7FE, 8'h59, 1'b1, 11'h3FF);
    chk("half_2", bus.QB, 16'h5A00);
    cyc(1'b0, 1'b1, 1'b1, 12'h7FE, 8'h52, 1'b1, 11'h3FF);
    chk("half_3", bus.QB, 16'h5A59);
    rd(11'h3FF);
    chk("half_final", bus.QB, 16'h5A52);
    rd(11'h7FF);
    chk("top_intact", bus.QB, 16'h4446);

    // Partial enables must not write.
    cyc(1'b0, 1'b0, 1'b1, 12'h000, 8'hFF, 1'b0, 11'h000);
    cyc(1'b0, 1'b1, 1'b0, 12'h001, 8'h77, 1'b0, 11'h000);
    rd(11'h000);
    chk("no_write", bus.QB, 16'h0000);

    // Reset wins over ClockEnB and leaves memory contents alone.
    rd(11'h7FF);
    cyc(1'b1, 1'b0, 1'b0, 12'h000, 8'h00, 1'b1, 11'h7FF);
    chk("reset_prio", bus.QB, 16'h0000);
    rd(11'h7FF);
    chk("mem_survives", bus.QB, 16'h4446);

    // Random traffic, addresses often clustered to provoke collisions.
    for (int i = 0; i < 3000; i++) begin
      logic [11:0] aa;
      logic [10:0] ab;
      bit          near;
      near = ($urandom_range(0, 3) != 0);
      aa = near ? 12'($urandom_range(0, 15)) : 12'($urandom);
      ab = near ? 11'($urandom_range(0, 7))  : 11'($urandom);
      cyc(($urandom_range(0, 63) == 0),
          1'($urandom), 1'($urandom), aa, 8'($urandom),
          ($urandom_range(0, 3) != 0), ab);
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
